// File: rtl/addsub_serial_param.sv
// Digit-serial signed/unsigned adder-subtractor: CHUNK bits per cycle, valid/ready in and out.
// Build option: define ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module addsub_serial_param #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovfl,
   output logic             carry,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sh;
   logic             c;
   logic             mode_r;
   logic [CW-1:0]    count;
`ifdef ADDSUB_SATURATE_EN
   logic             sign_a;
`endif

   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] next_sh;
   logic             cin_msb;
   logic             ovf_next;
   logic [WIDTH-1:0] final_res;

   always_comb begin
      chunk_sum = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, c};
      next_sh   = (sh >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
      // On the last chunk this recovers the carry into bit WIDTH-1 from the top sum bit.
      cin_msb   = opa[CHUNK-1] ^ opb[CHUNK-1] ^ chunk_sum[CHUNK-1];
      ovf_next  = cin_msb ^ chunk_sum[CHUNK];
      final_res = next_sh;
`ifdef ADDSUB_SATURATE_EN
      if (ovf_next) begin
         final_res = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Handshake: a transfer happens on any rising edge where valid && ready are both high;
   // in_ready depends on state only, and result/flags stay frozen while out_valid waits for out_ready.
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         opa       <= '0;
         opb       <= '0;
         sh        <= '0;
         c         <= 1'b0;
         mode_r    <= 1'b0;
         result    <= '0;
         ovfl      <= 1'b0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
         sign_a    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa    <= a;
                  opb    <= mode ? ~b : b;
                  c      <= mode;
                  mode_r <= mode;
                  count  <= '0;
                  state  <= BUSY;
`ifdef ADDSUB_SATURATE_EN
                  sign_a <= a[WIDTH-1];
`endif
               end
            end
            BUSY: begin
               opa   <= opa >> CHUNK;
               opb   <= opb >> CHUNK;
               sh    <= next_sh;
               c     <= chunk_sum[CHUNK];
               count <= count + 1'b1;
               if (count == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= final_res;
                  ovfl      <= ovf_next;
                  carry     <= mode_r ? ~chunk_sum[CHUNK] : chunk_sum[CHUNK];
                  zero      <= (final_res == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial_param.sv
// Bench for addsub_serial_param: directed plan vectors, backpressure, mid-op reset and random ops
// checked against an integer-arithmetic reference model.
module tb_addsub_serial_param;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         ovfl;
   logic         carry;
   logic         zero;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   logic [2:0]   expf_q[$];   // {ovfl, carry, zero}

   addsub_serial_param #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovfl(ovfl), .carry(carry), .zero(zero)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checkers ----------------
   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                 output logic [W-1:0] r, output logic [2:0] f);
      longint lim, ux, uy, sx, sy, ures, sres;
      logic   v, cb;
      lim = longint'(1) << W;
      ux  = longint'(x);
      uy  = longint'(y);
      sx  = (ux >= lim / 2) ? ux - lim : ux;
      sy  = (uy >= lim / 2) ? uy - lim : uy;
      if (m) begin
         ures = ux - uy;
         sres = sx - sy;
         cb   = (ux < uy);
      end else begin
         ures = ux + uy;
         sres = sx + sy;
         cb   = (ures >= lim);
      end
      v = (sres >= lim / 2) || (sres < -(lim / 2));
      r = W'(ures);
`ifdef ADDSUB_SATURATE_EN
      if (v) r = (sres > 0) ? W'(lim / 2 - 1) : W'(lim / 2);
`endif
      f = {v, cb, (r == '0)};
   endfunction

   // ---------------- drivers ----------------
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m, input bit keep);
      logic [W-1:0] r;
      logic [2:0]   f;
      int           n;
      @(negedge clk);
      a = x; b = y; mode = m; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_bit("accept_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (keep) begin
         model(x, y, m, r, f);
         exp_q.push_back(r);
         expf_q.push_back(f);
      end
   endtask

   task automatic receive(input int hold, input bit chk_lat);
      logic [W-1:0] r;
      logic [2:0]   f;
      int           n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_bit("out_valid_seen", out_valid, 1'b1);
      if (chk_lat) check_int("latency", n, NCH);
      check_int("sb_pending", exp_q.size(), 1);
      r = exp_q.pop_front();
      f = expf_q.pop_front();
      repeat (hold) begin
         check_bit("hold_valid", out_valid, 1'b1);
         check_word("hold_result", result, r);
         @(negedge clk);
      end
      check_word("result", result, r);
      check_bit("ovfl", ovfl, f[2]);
      check_bit("carry", carry, f[1]);
      check_bit("zero", zero, f[0]);
      check_bit("in_ready_done", in_ready, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check_bit("out_valid_drop", out_valid, 1'b0);
      check_bit("in_ready_idle", in_ready, 1'b1);
      check_word("result_kept", result, r);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] r;
      logic [2:0]   f;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         seen;
      int           n;
      logic [W-1:0] edge_vals[6];
      edge_vals = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_word("rst_result", result, '0);
      check_bit("rst_ovfl", ovfl, 1'b0);
      check_bit("rst_carry", carry, 1'b0);
      check_bit("rst_zero", zero, 1'b0);

      // plan vectors
      send(16'h1234, 16'h0F0F, 1'b0, 1'b1); receive(0, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b1); receive(0, 1'b1);
      send(16'h0000, 16'h8000, 1'b1, 1'b1); receive(0, 1'b1);
      send(16'h0005, 16'h0003, 1'b1, 1'b1); receive(0, 1'b1);
      send(16'h0003, 16'h0003, 1'b1, 1'b1); receive(0, 1'b1);
      send(16'hFFFF, 16'h0001, 1'b0, 1'b1); receive(0, 1'b1);
      send(16'h8000, 16'h0001, 1'b1, 1'b1); receive(2, 1'b1);

      // backpressure with a competing in_valid while DONE
      send(16'h1111, 16'h2222, 1'b0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_bit("bp_valid", out_valid, 1'b1);
      r = exp_q.pop_front();
      f = expf_q.pop_front();
      a = 16'hAAAA; b = 16'h5555; mode = 1'b0; in_valid = 1'b1;
      repeat (5) begin
         check_bit("bp_hold_valid", out_valid, 1'b1);
         check_bit("bp_in_ready", in_ready, 1'b0);
         check_word("bp_result", result, r);
         check_bit("bp_ovfl", ovfl, f[2]);
         check_bit("bp_carry", carry, f[1]);
         check_bit("bp_zero", zero, f[0]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check_bit("bp_release_valid", out_valid, 1'b0);
      check_bit("bp_release_ready", in_ready, 1'b1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check_bit("bp_not_queued", seen, 1'b0);
      send(16'hAAAA, 16'h5555, 1'b0, 1'b1); receive(0, 1'b1);

      // reset during BUSY after two chunks
      send(16'h4321, 16'h1234, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_bit("mid_rst_in_ready", in_ready, 1'b1);
      check_bit("mid_rst_out_valid", out_valid, 1'b0);
      check_word("mid_rst_result", result, '0);
      check_bit("mid_rst_ovfl", ovfl, 1'b0);
      check_bit("mid_rst_carry", carry, 1'b0);
      check_bit("mid_rst_zero", zero, 1'b0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check_bit("abort_no_result", seen, 1'b0);
      send(16'h0001, 16'h0001, 1'b0, 1'b1); receive(0, 1'b1);

      // random operations, biased toward boundary operands
      for (int i = 0; i < 40; i++) begin
         x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom_range(0, 65535));
         y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom_range(0, 65535));
         send(x, y, 1'($urandom_range(0, 1)), 1'b1);
         receive($urandom_range(0, 3), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addsub_serial_param.md
Name: addsub_serial_param

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor; next generation of the team's 8-bit combinational add/sub unit.
- Processes operands CHUNK bits per cycle (digit-serial) to trade latency for area.
- Uses a valid/ready handshake on input and output.
- Produces signed overflow, unsigned carry/borrow and zero flags; optional saturation.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK, minimum 4.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- mode  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum or difference.
- ovfl  output  1  signed two's-complement overflow.
- carry  output  1  add: unsigned carry-out; sub: unsigned borrow (1 when a < b unsigned).
- zero  output  1  result == 0 (after saturation, if enabled).

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM goes to IDLE; counter cleared.
  - result=0, ovfl=0, carry=0, zero=0, out_valid=0, in_ready=1 on the following cycle.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a into opa, latch (mode ? ~b : b) into opb; carry register = mode; count=0; go to BUSY.
- BUSY:
  - in_ready=0; inputs are ignored.
  - Each cycle: {c, sum} = opa[CHUNK-1:0] + opb[CHUNK-1:0] + c, using CHUNK+1 bit arithmetic.
  - sum is shifted into the top of the result shift register; opa and opb are shifted right by CHUNK.
  - The carry into the MSB (bit WIDTH-1) is captured on the last chunk.
  - count increments; after chunk NCHUNK-1 go to DONE.
- Flags, registered on entry to DONE:
  - ovfl = carry into MSB XOR carry out of MSB. This equals the sign rule (opa and opb signs equal, result sign differs). Subtract is a + ~b + 1, so b = most negative value is handled correctly.
  - carry = mode ? ~cout : cout.
  - zero = (final result == 0).
- DONE:
  - out_valid=1; result and flags held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE; out_valid drops next cycle; result and flags keep their last value.
- Latency: accept edge at cycle 0; out_valid is high from cycle NCHUNK (4 for the defaults).
- Throughput: one operation per NCHUNK+2 cycles with out_ready held high.
- in_ready is combinational from state only; no combinational path from in_valid or out_ready to any output.
- in_valid raised during BUSY or DONE is not accepted and not queued.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when ovfl=1, result is clamped. If the latched opa sign is 0, result = max positive (0 followed by WIDTH-1 ones). If the sign is 1, result = min negative (1 followed by WIDTH-1 zeros). ovfl still reads 1; carry is unaffected; zero is computed on the clamped value.
- Not defined: result is the wrapped modulo-2^WIDTH value; no clamp logic is synthesised.

Test Plan (WIDTH=16, CHUNK=4):
- Add 0x1234 + 0x0F0F, mode=0 -> result 0x2143, ovfl=0, carry=0, zero=0; out_valid exactly 4 cycles after accept.
- Add 0x7FFF + 0x0001 -> result 0x8000, ovfl=1, carry=0. With ADDSUB_SATURATE_EN: result 0x7FFF, ovfl=1.
- Sub 0x0000 - 0x8000, mode=1 -> result 0x8000, ovfl=1, carry(borrow)=1. With saturation: 0x7FFF. Sub 0x0005 - 0x0003 -> 0x0002, borrow=0. Sub 0x0003 - 0x0003 -> 0x0000, zero=1, borrow=0.
- Add 0xFFFF + 0x0001 -> result 0x0000, carry=1, ovfl=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving a new in_valid -> result and flags stable, in_ready=0, new op not accepted. Release out_ready -> IDLE next cycle; new op accepted afterwards and computed correctly.
- Assert rst for 1 cycle during BUSY (count=2) -> next cycle IDLE, out_valid=0, in_ready=1, all outputs 0. A following 0x0001 + 0x0001 yields 0x0002.
